// File: rtl/sub_pkg.sv
// Shared definitions for the subtractor result stage: default widths, the
// occupancy state encoding and the stored sign-magnitude result type.
package sub_pkg;

    localparam int SIZE_DEF  = 32;
    localparam int CNT_W_DEF = 16;

    // Number of results held by the stage; the skid entry is used only in TWO.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_e;

    // Converted result as stored in both the main and skid registers.
    typedef struct packed {
        logic [SIZE_DEF-1:0] mag;
        logic                neg;
        logic                zero;
    } sub_res_t;

    // Value presented on out_* straight after reset.
    localparam sub_res_t RES_RESET = '{mag: '0, neg: 1'b0, zero: 1'b1};

endpackage

// File: rtl/sub_mag_conv.sv
// Combinational conversion of a raw difference and borrow-out into
// sign-magnitude form. With br=1 and d=0 (impossible from a real subtractor)
// the output is mag=0, neg=1, zero=1; it is passed through unchanged.
module sub_mag_conv
    import sub_pkg::*;
#(
    parameter int SIZE = SIZE_DEF
) (
    input  logic [SIZE-1:0] in_d,
    input  logic            in_br,
    output logic [SIZE-1:0] mag,
    output logic            neg,
    output logic            zero
);

    // Two's-complement negate when the subtraction borrowed.
    always_comb begin
        mag  = in_br ? (~in_d + SIZE'(1)) : in_d;
        neg  = in_br;
        zero = (mag == '0);
    end

endmodule

// File: rtl/sub_result_stage.sv
// Registered output stage behind the parallel subtractor. Converts D/Br to
// sign-magnitude and presents it on a valid/ready interface backed by a
// 2-entry skid buffer (main register drives out_*, skid register is second).
// in_ready is a pure decode of the registered occupancy, so there is no
// combinational path from out_ready to in_ready.
// Optional feature: define SUB_BORROW_CNT_EN to add the saturating borrow_cnt
// port counting accepted inputs with in_br=1.
// Stored results use sub_pkg::sub_res_t, so SIZE must equal SIZE_DEF.
module sub_result_stage
    import sub_pkg::*;
#(
    parameter int SIZE = SIZE_DEF
`ifdef SUB_BORROW_CNT_EN
    ,
    parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  in_d,
    input  logic             in_br,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  out_mag,
    output logic             out_neg,
    output logic             out_zero
`ifdef SUB_BORROW_CNT_EN
    ,
    output logic [CNT_W-1:0] borrow_cnt
`endif
);

    occ_state_e      state_q, state_d;
    sub_res_t        main_q, main_d;
    sub_res_t        skid_q, skid_d;
    sub_res_t        conv_res;
    logic [SIZE-1:0] conv_mag;
    logic            conv_neg;
    logic            conv_zero;
    logic            push;
    logic            pop;

    // Single converter on the input side; both registers store converted results.
    sub_mag_conv #(.SIZE(SIZE)) u_conv (
        .in_d  (in_d),
        .in_br (in_br),
        .mag   (conv_mag),
        .neg   (conv_neg),
        .zero  (conv_zero)
    );

    assign conv_res  = '{mag: conv_mag, neg: conv_neg, zero: conv_zero};

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next occupancy and register contents from the push/pop combination.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    main_d  = conv_res;
                end
            end
            ONE: begin
                if (push && pop) begin
                    main_d  = conv_res;
                end else if (push) begin
                    state_d = TWO;
                    skid_d  = conv_res;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= RES_RESET;
            // NOTE: the skid entry is cleared too, so no pre-reset data is ever retained.
            skid_q  <= RES_RESET;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_mag  = main_q.mag;
    assign out_neg  = main_q.neg;
    assign out_zero = main_q.zero;

`ifdef SUB_BORROW_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Count accepted inputs that borrowed, holding at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (push && in_br && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign borrow_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sub_result_stage.sv
// Scoreboard bench for sub_result_stage: the driver pushes the expected
// sign-magnitude result when a transfer is accepted, a monitor pops and
// compares whenever the DUT presents an output that is taken.
module tb_sub_result_stage;
    import sub_pkg::*;

    localparam int SIZE = SIZE_DEF;
    localparam logic [SIZE:0] MOD_SIZE = {1'b1, {SIZE{1'b0}}};
`ifdef SUB_BORROW_CNT_EN
    localparam int TB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
    logic [TB_CNT_W-1:0] borrow_cnt;
    int                  exp_cnt = 0;
`endif

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_d;
    logic            in_br;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_mag;
    logic            out_neg;
    logic            out_zero;

    int       checks = 0;
    int       errors = 0;
    int       rdy_mode = 1;   // 0: out_ready low, 1: high, 2: random
    int       last_wait = 0;
    sub_res_t exp_q[$];

    sub_result_stage #(
        .SIZE(SIZE)
`ifdef SUB_BORROW_CNT_EN
        , .CNT_W(TB_CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_d      (in_d),
        .in_br     (in_br),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag   (out_mag),
        .out_neg   (out_neg),
        .out_zero  (out_zero)
`ifdef SUB_BORROW_CNT_EN
        , .borrow_cnt(borrow_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: magnitude of the signed difference, from modular arithmetic.
    function automatic sub_res_t model(input logic [SIZE-1:0] d, input logic br);
        sub_res_t      r;
        logic [SIZE:0] wide;
        wide   = br ? (MOD_SIZE - {1'b0, d}) : {1'b0, d};
        r.mag  = wide[SIZE-1:0];
        r.neg  = br;
        r.zero = (wide[SIZE-1:0] == 0);
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one input until accepted; returns at posedge+1 after the transfer edge.
    task automatic push(input logic [SIZE-1:0] d, input logic br);
        int waited = 0;
        bit done = 0;
        bit accepted = 0;
        in_valid = 1'b1;
        in_d     = d;
        in_br    = br;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(d, br));
                accepted = 1;
                done     = 1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (waited > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL push_timeout: got no in_ready within %0d cycles, expected acceptance", waited);
                    done = 1;
                end
            end
        end
        last_wait = waited;
        in_valid  = 1'b0;
        in_d      = SIZE'($urandom);
        in_br     = 1'($urandom);
`ifdef SUB_BORROW_CNT_EN
        if (accepted && br && exp_cnt < CNT_MAX) exp_cnt++;
        check("borrow_cnt", 64'(borrow_cnt), 64'(exp_cnt));
`endif
    endtask

    // out_ready driver.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: scoreboard pop on every taken output, plus stall stability.
    sub_res_t held;
    bit       hold_pending = 0;
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 0;
        end else begin
            if (hold_pending && out_valid)
                check("stall_stable", 64'({out_mag, out_neg, out_zero}), 64'(held));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got mag=%h neg=%b zero=%b, expected no output",
                             out_mag, out_neg, out_zero);
                end else begin
                    check("scoreboard", 64'({out_mag, out_neg, out_zero}), 64'(exp_q.pop_front()));
                end
            end
            hold_pending = out_valid && !out_ready;
            held         = '{mag: out_mag, neg: out_neg, zero: out_zero};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        int              wait_sum;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_d     = '0;
        in_br    = 1'b0;
        rdy_mode = 1;

        // Reset for two cycles, then release.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_mag",   64'(out_mag),   64'd0);
        check("reset_out_neg",   64'(out_neg),   64'd0);
        check("reset_out_zero",  64'(out_zero),  64'd1);
`ifdef SUB_BORROW_CNT_EN
        check("reset_borrow_cnt", 64'(borrow_cnt), 64'd0);
`endif
        idle(1);

        // Latency from EMPTY is one cycle.
        push(32'h0000_000A, 1'b0);
        check("latency_valid", 64'(out_valid), 64'd1);
        check("latency_mag",   64'(out_mag),   64'h0000_000A);
        check("latency_neg",   64'(out_neg),   64'd0);
        check("latency_zero",  64'(out_zero),  64'd0);

        // Negative, zero and the pass-through br=1/d=0 case.
        push(32'hFFFF_FFFB, 1'b1);
        push(32'h0000_0000, 1'b0);
        push(32'h0000_0000, 1'b1);
        idle(2);

        // Fill both entries with a stalled consumer, then drain in order.
        rdy_mode = 0;
        idle(2);
        push(32'd1, 1'b0);
        check("one_entry_in_ready", 64'(in_ready), 64'd1);
        push(32'd2, 1'b0);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head_mag", 64'(out_mag),  64'd1);
        idle(3);
        check("full_hold_in_ready", 64'(in_ready), 64'd0);
        rdy_mode = 1;
        idle(4);
        check("drained_in_ready", 64'(in_ready), 64'd1);
        check("drained_queue",    64'(exp_q.size()), 64'd0);

        // Back-to-back pushes with out_ready high never stall.
        wait_sum = 0;
        for (int i = 0; i < 8; i++) begin
            push(SIZE'($urandom), 1'($urandom));
            wait_sum += last_wait;
        end
        check("throughput_stalls", 64'(wait_sum), 64'd0);
        idle(3);

        // Reset while holding two entries discards both.
        rdy_mode = 0;
        idle(2);
        push(32'd3, 1'b0);
        push(32'd4, 1'b1);
        check("pre_reset_full", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_in_ready",  64'(in_ready),  64'd1);
        check("midreset_out_mag",   64'(out_mag),   64'd0);
        check("midreset_out_zero",  64'(out_zero),  64'd1);
`ifdef SUB_BORROW_CNT_EN
        exp_cnt = 0;
        check("midreset_borrow_cnt", 64'(borrow_cnt), 64'd0);
`endif
        rdy_mode = 1;
        idle(5);

`ifdef SUB_BORROW_CNT_EN
        // Five borrows saturate the 2-bit counter: 1,2,3,3,3.
        for (int i = 0; i < 5; i++) push(SIZE'($urandom), 1'b1);
        idle(2);
`endif

        // Randomized traffic with random back-pressure.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = SIZE'($urandom_range(0, 3));
                b = SIZE'($urandom_range(0, 3));
            end else begin
                a = SIZE'($urandom);
                b = SIZE'($urandom);
            end
            push(a - b, (a < b));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        // Drain everything still expected.
        rdy_mode = 1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
        idle(2);
        check("final_drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
